// File: rtl/rv32i_types.sv
// ============================================================================
// Package : rv32i_types
// Purpose : Shared result-bus types for the RV32I out-of-order core. Holds the
//           common data bus (CDB) packet and bus types used by producers
//           (functional units) and consumers (reservation stations, ROB).
// Contents: c_TAG_W / c_ID_W / c_XLEN  - field widths of the broadcast packet
//           cdb_pkt_t                  - {tag, inst_id, wdata}
//           cdb_bus_t                  - {wr, pkt}, one broadcast beat
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

  // Packet fields are sized for the core's rename tag and ROB slot widths.
  // Modules carrying narrower tags/ids zero-extend into these fields.
  localparam int c_TAG_W = 4;
  localparam int c_ID_W  = 4;
  localparam int c_XLEN  = 32;

  typedef struct packed {
    logic [c_TAG_W-1:0] tag;
    logic [c_ID_W-1:0]  inst_id;
    logic [c_XLEN-1:0]  wdata;
  } cdb_pkt_t;

  typedef struct packed {
    logic     wr;
    cdb_pkt_t pkt;
  } cdb_bus_t;

  localparam int c_PKT_W = $bits(cdb_pkt_t);

endpackage

`default_nettype wire

// File: rtl/cdb_fifo.sv
// ============================================================================
// Module  : cdb_fifo
// Purpose : Small per-functional-unit result buffer in front of the CDB
//           arbiter. First-word-fall-through: o_head is the oldest entry.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_push        - write i_wdata (ignored when full)
//           i_wdata       - entry to write
//           i_pop         - drop the head entry (ignored when empty)
//           o_full        - no free entry
//           o_empty       - no valid entry
//           o_head        - oldest entry (undefined when empty)
// Params  : WIDTH - entry width; DEPTH - entry count, power of two, >= 2
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == c_CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module  : cdb_arbiter
// Purpose : Collects results from NUM_FU functional units (0=ALU, 1=MDU,
//           2=LSU) into per-FU buffers and broadcasts at most one result per
//           cycle on the common data bus, chosen by round-robin.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           fu_valid/fu_ready   - per-FU result handshake
//           fu_tag/fu_inst_id/fu_wdata - per-FU result fields (flattened)
//           cdb_wr              - broadcast valid (registered)
//           cdb_tag/cdb_inst_id/cdb_wdata - broadcast fields (registered,
//                                 hold their last value when cdb_wr=0)
// Config  : CDB_ARBITER_BYPASS_EN - when defined, a result offered to an
//           empty buffer competes in the same cycle and, if granted, skips
//           the buffer (one-cycle latency). Undefined: all results go
//           through the buffer (two-cycle minimum latency).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_FU     = 3,
  parameter int TAG_W      = 4,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*ID_W-1:0]   fu_inst_id,
  input  logic [NUM_FU*32-1:0]     fu_wdata,
  output logic                     cdb_wr,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [ID_W-1:0]          cdb_inst_id,
  output logic [31:0]              cdb_wdata
);

  localparam int c_RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  cdb_pkt_t            w_fu_pkt [NUM_FU];
  cdb_pkt_t            w_head   [NUM_FU];
  logic [NUM_FU-1:0]   w_full;
  logic [NUM_FU-1:0]   w_empty;
  logic [NUM_FU-1:0]   w_req;
  logic [NUM_FU-1:0]   w_grant;
  logic [NUM_FU-1:0]   w_push;
  logic [NUM_FU-1:0]   w_pop;
  logic [NUM_FU-1:0]   w_bypass;
  logic [c_RR_W-1:0]   w_grant_idx;
  logic                w_grant_any;
  cdb_pkt_t            w_sel_pkt;
  logic [c_RR_W-1:0]   r_rr_ptr;
  cdb_bus_t            r_cdb;

  // Ready depends only on buffer state, never on the pop in the same cycle.
  assign fu_ready = ~w_full;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    assign w_fu_pkt[gi].tag     = c_TAG_W'(fu_tag[gi*TAG_W +: TAG_W]);
    assign w_fu_pkt[gi].inst_id = c_ID_W'(fu_inst_id[gi*ID_W +: ID_W]);
    assign w_fu_pkt[gi].wdata   = fu_wdata[gi*32 +: 32];

`ifdef CDB_ARBITER_BYPASS_EN
    // An offer to an empty buffer may be granted straight away; ordering is
    // preserved because the buffer holds nothing older.
    assign w_req[gi]    = ~w_empty[gi] | fu_valid[gi];
    assign w_bypass[gi] = w_grant[gi] & w_empty[gi];
`else
    assign w_req[gi]    = ~w_empty[gi];
    assign w_bypass[gi] = 1'b0;
`endif

    assign w_push[gi] = fu_valid[gi] & ~w_full[gi] & ~w_bypass[gi];
    assign w_pop[gi]  = w_grant[gi] & ~w_empty[gi];

    cdb_fifo #(
      .WIDTH (c_PKT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[gi]),
      .i_wdata (w_fu_pkt[gi]),
      .i_pop   (w_pop[gi]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi]),
      .o_head  (w_head[gi])
    );
  end

  // Round-robin: scan from r_rr_ptr upward, wrapping at NUM_FU; first
  // requester wins.
  always_comb begin : p_arb
    int                w_scan;
    logic [c_RR_W-1:0] w_idx;
    w_grant     = '0;
    w_grant_idx = r_rr_ptr;
    w_grant_any = 1'b0;
    w_scan      = 0;
    w_idx       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_scan = int'(r_rr_ptr) + k;
      if (w_scan >= NUM_FU) w_scan = w_scan - NUM_FU;
      w_idx = c_RR_W'(w_scan);
      if (!w_grant_any && w_req[w_idx]) begin
        w_grant_any    = 1'b1;
        w_grant_idx    = w_idx;
        w_grant[w_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_pkt = w_head[w_grant_idx];
`ifdef CDB_ARBITER_BYPASS_EN
    if (w_empty[w_grant_idx]) w_sel_pkt = w_fu_pkt[w_grant_idx];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cdb    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_cdb.wr <= w_grant_any;
      if (w_grant_any) begin
        r_cdb.pkt <= w_sel_pkt;
        r_rr_ptr  <= (w_grant_idx == c_RR_W'(NUM_FU - 1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  assign cdb_wr      = r_cdb.wr;
  assign cdb_tag     = TAG_W'(r_cdb.pkt.tag);
  assign cdb_inst_id = ID_W'(r_cdb.pkt.inst_id);
  assign cdb_wdata   = r_cdb.pkt.wdata;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module  : tb_cdb_arbiter
// Purpose : Self-checking bench for cdb_arbiter: reset state, contention
//           order, single-request vectors, idle hold, backpressure, fairness
//           and mid-run reset.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cdb_arbiter;

  localparam int NUM_FU     = 3;
  localparam int TAG_W      = 4;
  localparam int ID_W       = 4;
  localparam int FIFO_DEPTH = 2;
`ifdef CDB_ARBITER_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  fu_valid;
  logic [2:0]  fu_ready;
  logic [11:0] fu_tag;
  logic [11:0] fu_inst_id;
  logic [95:0] fu_wdata;
  logic        cdb_wr;
  logic [3:0]  cdb_tag;
  logic [3:0]  cdb_inst_id;
  logic [31:0] cdb_wdata;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_FU     (NUM_FU),
    .TAG_W      (TAG_W),
    .ID_W       (ID_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fu_valid    (fu_valid),
    .fu_ready    (fu_ready),
    .fu_tag      (fu_tag),
    .fu_inst_id  (fu_inst_id),
    .fu_wdata    (fu_wdata),
    .cdb_wr      (cdb_wr),
    .cdb_tag     (cdb_tag),
    .cdb_inst_id (cdb_inst_id),
    .cdb_wdata   (cdb_wdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          fu;
    logic [3:0]  tag;
    logic [3:0]  id;
    logic [31:0] data;
    logic [3:0]  exp_tag;
    logic [3:0]  exp_id;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs [6];

  // Scoreboard state
  logic [39:0] q0[$];
  logic [39:0] q1[$];
  logic [39:0] q2[$];
  int seq [3];
  int lim [3];
  int acc_n [3];
  int bc_n [3];
  int acc_cyc [3];
  int cyc;
  bit fair_mode;
  bit saw_mdu_full;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int f, input logic v, input logic [3:0] t,
                        input logic [3:0] i, input logic [31:0] d);
    fu_valid[f]          = v;
    fu_tag[f*4 +: 4]     = t;
    fu_inst_id[f*4 +: 4] = i;
    fu_wdata[f*32 +: 32] = d;
  endtask

  task automatic clear_all();
    for (int f = 0; f < 3; f++) set_fu(f, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic check_cdb(input string nm, input logic [3:0] t, input logic [3:0] i,
                           input logic [31:0] d);
    check({nm, "_wr"}, cdb_wr, 1'b1);
    check({nm, "_tag"}, cdb_tag, t);
    check({nm, "_id"}, cdb_inst_id, i);
    check({nm, "_data"}, cdb_wdata, d);
  endtask

  function automatic int q_size(input int f);
    case (f)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_push(input int f, input logic [39:0] v);
    case (f)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic q_pop(input int f, output logic [39:0] v);
    case (f)
      0:       v = q0.pop_front();
      1:       v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  function automatic logic [3:0] sb_tag(input int f, input int s);
    return 4'((s * 3 + f + 1) % 16);
  endfunction

  function automatic logic [31:0] sb_data(input int f, input int s);
    return {4'(f), 12'h0A5, 16'(s)};
  endfunction

  task automatic sb_reset();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) begin
      seq[i] = 0; lim[i] = 0; acc_n[i] = 0; bc_n[i] = 0; acc_cyc[i] = 0;
    end
    cyc = 0;
    fair_mode = 1'b0;
    saw_mdu_full = 1'b0;
  endtask

  // One clock of scoreboard-driven traffic: offer, record acceptances, check
  // any broadcast against the oldest accepted result of its FU, and check
  // ready against the occupancy the bench has tracked.
  task automatic sb_cycle();
    logic [2:0]  acc;
    logic [39:0] pk [3];
    logic [39:0] exp;
    int          f;
    for (int i = 0; i < 3; i++) begin
      if (seq[i] < lim[i]) set_fu(i, 1'b1, sb_tag(i, seq[i]), 4'(seq[i]), sb_data(i, seq[i]));
      else                 set_fu(i, 1'b0, 4'h0, 4'h0, 32'h0);
      pk[i] = {fu_tag[i*4 +: 4], fu_inst_id[i*4 +: 4], fu_wdata[i*32 +: 32]};
    end
    acc = fu_valid & fu_ready;
    tick();
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        q_push(i, pk[i]);
        seq[i]++;
        acc_n[i]++;
        acc_cyc[i] = cyc;
      end
    end
    if (cdb_wr === 1'b1) begin
      f = int'(cdb_wdata[31:28]);
      if (f < 3 && q_size(f) > 0) begin
        q_pop(f, exp);
        bc_n[f]++;
        check("sb_pkt", {cdb_tag, cdb_inst_id, cdb_wdata}, exp);
        if (fair_mode && f == 2) check("lsu_wait_le_3", (cyc - acc_cyc[2]) <= 3, 1'b1);
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_spurious: got broadcast data 0x%0h, expected none", cdb_wdata);
      end
    end
    for (int i = 0; i < 3; i++) begin
      check("ready_vs_occ", fu_ready[i], (acc_n[i] - bc_n[i]) < FIFO_DEPTH);
      if (i == 1 && (acc_n[1] - bc_n[1]) == FIFO_DEPTH) saw_mdu_full = 1'b1;
    end
  endtask

  task automatic sb_drain();
    lim[0] = seq[0]; lim[1] = seq[1]; lim[2] = seq[2];
    for (int k = 0; k < 30 && (q0.size() + q1.size() + q2.size()) > 0; k++) sb_cycle();
    check("drained", q0.size() + q1.size() + q2.size(), 0);
  endtask

  // All three FUs offer in the same cycle; expected order ALU, MDU, LSU.
  task automatic contention(input int rnd);
    for (int f = 0; f < 3; f++)
      set_fu(f, 1'b1, 4'(rnd * 3 + f + 1), 4'(8 + f), {4'(f), 28'(rnd)});
    tick();
    clear_all();
    for (int c = 1; c < LAT; c++) begin
      check("cont_early", cdb_wr, 1'b0);
      tick();
    end
    for (int f = 0; f < 3; f++) begin
      check_cdb("cont", 4'(rnd * 3 + f + 1), 4'(8 + f), {4'(f), 28'(rnd)});
      tick();
    end
    check("cont_after", cdb_wr, 1'b0);
  endtask

  initial begin
    vecs[0] = '{0, 4'h3, 4'h5, 32'hDEADBEEF, 4'h3, 4'h5, 32'hDEADBEEF};
    vecs[1] = '{1, 4'hF, 4'h0, 32'h00000000, 4'hF, 4'h0, 32'h00000000};
    vecs[2] = '{2, 4'h0, 4'hA, 32'hFFFFFFFF, 4'h0, 4'hA, 32'hFFFFFFFF};
    vecs[3] = '{0, 4'h0, 4'h0, 32'h00000000, 4'h0, 4'h0, 32'h00000000};
    vecs[4] = '{1, 4'h9, 4'hF, 32'h12345678, 4'h9, 4'hF, 32'h12345678};
    vecs[5] = '{2, 4'h1, 4'h1, 32'h80000001, 4'h1, 4'h1, 32'h80000001};

    fu_valid = '0; fu_tag = '0; fu_inst_id = '0; fu_wdata = '0;
    sb_reset();

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_wr", cdb_wr, 1'b0);
    check("rst_tag", cdb_tag, 4'h0);
    check("rst_id", cdb_inst_id, 4'h0);
    check("rst_data", cdb_wdata, 32'h0);
    check("rst_ready", fu_ready, 3'b111);

    // Contention from rr_ptr=0, twice: the second round proves rr_ptr is 0 again
    contention(0);
    contention(1);

    // Single-request vectors
    for (int v = 0; v < 6; v++) begin
      set_fu(vecs[v].fu, 1'b1, vecs[v].tag, vecs[v].id, vecs[v].data);
      tick();
      clear_all();
      for (int c = 1; c < LAT; c++) begin
        check("single_early", cdb_wr, 1'b0);
        tick();
      end
      check_cdb("single", vecs[v].exp_tag, vecs[v].exp_id, vecs[v].exp_data);
      tick();
      check("single_after", cdb_wr, 1'b0);
      check("single_ready", fu_ready, 3'b111);
    end

    // Idle: no broadcast, fields hold the last broadcast values
    for (int c = 0; c < 10; c++) begin
      check("idle_wr", cdb_wr, 1'b0);
      check("idle_hold", {cdb_tag, cdb_inst_id, cdb_wdata}, {4'h1, 4'h1, 32'h80000001});
      tick();
    end

    // Backpressure: ALU and LSU saturate, MDU offers 3 back-to-back
    sb_reset();
    lim[0] = 1000; lim[1] = 3; lim[2] = 1000;
    for (int c = 0; c < 14; c++) sb_cycle();
    sb_drain();
    check("bp_mdu_count", bc_n[1], 3);
    check("bp_mdu_full_seen", saw_mdu_full, 1'b1);

    // Fairness: ALU continuously valid, LSU valid once
    sb_reset();
    lim[0] = 1000;
    for (int c = 0; c < 4; c++) sb_cycle();
    lim[2] = 1;
    fair_mode = 1'b1;
    for (int c = 0; c < 10 && bc_n[2] == 0; c++) sb_cycle();
    check("fair_lsu_seen", bc_n[2], 1);
    fair_mode = 1'b0;
    sb_drain();

    // Mid-run reset with all buffers loaded
    sb_reset();
    lim[0] = 1000; lim[1] = 1000; lim[2] = 1000;
    for (int c = 0; c < 8; c++) sb_cycle();
    clear_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_wr", cdb_wr, 1'b0);
    check("mrst_ready", fu_ready, 3'b111);
    check("mrst_fields", {cdb_tag, cdb_inst_id, cdb_wdata}, 40'h0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("mrst_no_stale", cdb_wr, 1'b0);
    end
    check("mrst_ready_after", fu_ready, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
